mem_access_unit: RTL and testbench

Initiator side of the data-memory port: accepts load/store requests from the execute/memory stage and sequences the `mem_read`/`mem_write`/`mem_addr`/`mem_wdata` strobes toward the word-addressed data memory. It captures `mem_rdata` one cycle after a read strobe, then aligns and sign- or zero-extends the result. Sub-word stores are performed as read-modify-write, because the memory only writes whole words. It sits between the pipeline's memory stage and the data memory, with a valid/ready request and a valid/ready response.

---
 rtl/mem_access_unit_pkg.sv | 47 ++++
 rtl/mem_lane_align.sv | 59 +++++
 rtl/mem_access_unit.sv | 184 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_unit_pkg
// Shared definitions for the data-memory access unit:
//   - default data / byte-address width (taken from `WORD_WIDTH when defined)
//   - access size codes SIZE_B / SIZE_H / SIZE_W (11 is reserved)
//   - FSM state encodings
//   - request legality helper (alignment and size checks)
// Configuration macro: MEM_ACCESS_SUBWORD_EN enables byte/halfword accesses;
// without it only word accesses are legal.
// -----------------------------------------------------------------------------
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

package mem_access_unit_pkg;

    localparam int WORD_WIDTH_DEF = `WORD_WIDTH;

    localparam logic [1:0] SIZE_B   = 2'b00;
    localparam logic [1:0] SIZE_H   = 2'b01;
    localparam logic [1:0] SIZE_W   = 2'b10;
    localparam logic [1:0] SIZE_RSV = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } mau_state_t;

    // Returns 1 when a request of this size at this byte lane must be
    // rejected with an error response instead of touching memory.
    function automatic logic req_is_bad(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        case (size)
            SIZE_W:  bad = (lane != 2'b00);
`ifdef MEM_ACCESS_SUBWORD_EN
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = lane[0];
`endif
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Combinational byte-lane steering for sub-word accesses.
// Ports:
//   word        in  WORD_WIDTH : word read from memory
//   lane        in  2          : byte offset inside the word (addr[1:0])
//   size        in  2          : SIZE_B / SIZE_H / SIZE_W
//   is_unsigned in  1          : zero-extend loads when 1, sign-extend when 0
//   wdata       in  WORD_WIDTH : right-justified store data
//   load_val    out WORD_WIDTH : extracted and extended load value
//   merged      out WORD_WIDTH : word with store data merged into its lane
// Only instantiated when MEM_ACCESS_SUBWORD_EN is defined.
// -----------------------------------------------------------------------------
module mem_lane_align
    import mem_access_unit_pkg::*;
#(
    parameter int WORD_WIDTH = WORD_WIDTH_DEF
) (
    input  logic [WORD_WIDTH-1:0] word,
    input  logic [1:0]            lane,
    input  logic [1:0]            size,
    input  logic                  is_unsigned,
    input  logic [WORD_WIDTH-1:0] wdata,
    output logic [WORD_WIDTH-1:0] load_val,
    output logic [WORD_WIDTH-1:0] merged
);

    logic [4:0]  byte_sh_s;
    logic [4:0]  half_sh_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Halfwords use only lane[1]; lane[0] is guaranteed 0 by the alignment check.
    assign byte_sh_s = {lane, 3'b000};
    assign half_sh_s = {lane[1], 4'b0000};
    assign byte_s    = word[byte_sh_s +: 8];
    assign half_s    = word[half_sh_s +: 16];

    // Load extraction with sign or zero extension.
    always_comb begin
        load_val = word;
        case (size)
            SIZE_B:  load_val = {{(WORD_WIDTH-8){byte_s[7] & ~is_unsigned}}, byte_s};
            SIZE_H:  load_val = {{(WORD_WIDTH-16){half_s[15] & ~is_unsigned}}, half_s};
            default: load_val = word;
        endcase
    end

    // Store merge: replace only the addressed lane of the captured word.
    always_comb begin
        merged = word;
        case (size)
            SIZE_B:  merged[byte_sh_s +: 8]  = wdata[7:0];
            SIZE_H:  merged[half_sh_s +: 16] = wdata[15:0];
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Initiator side of the data-memory port. Accepts one load/store at a time,
// sequences read/write strobes to a word-addressed memory with one-cycle read
// latency, and performs sub-word stores as read-modify-write.
// Ports:
//   clk, rst (async, active-low)
//   req_valid/req_ready, req_we, req_size, req_unsigned, req_addr, req_wdata
//   resp_valid/resp_ready, resp_rdata, resp_err
//   mem_read, mem_write, mem_addr (word index), mem_wdata, mem_rdata
// Configuration macro: MEM_ACCESS_SUBWORD_EN enables byte/halfword loads
// (extract/extend) and stores (RMW). Without it only word accesses are legal
// and req_unsigned is ignored.
// FSM: IDLE -> RD -> CAP -> (WR) -> RESP for loads and sub-word stores,
//      IDLE -> WR -> RESP for word stores, IDLE -> RESP for errors.
// -----------------------------------------------------------------------------
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int WORD_WIDTH = WORD_WIDTH_DEF,
    parameter int MEM_AW     = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [WORD_WIDTH-1:0] req_addr,
    input  logic [WORD_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [WORD_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [WORD_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    input  logic [WORD_WIDTH-1:0] mem_rdata
);

    mau_state_t            state_r;
    mau_state_t            state_next_s;
    logic                  accept_s;
    logic                  bad_s;
    logic                  we_r;
    logic [MEM_AW-1:0]     word_idx_r;
    logic [WORD_WIDTH-1:0] mem_wdata_r;
    logic [WORD_WIDTH-1:0] resp_rdata_r;
    logic                  resp_err_r;
    logic                  unused_s;

    assign accept_s = req_valid && (state_r == ST_IDLE);
    assign bad_s    = req_is_bad(req_size, req_addr[1:0]);

`ifdef MEM_ACCESS_SUBWORD_EN
    logic [1:0]            size_r;
    logic                  uns_r;
    logic [1:0]            lane_r;
    logic [WORD_WIDTH-1:0] wdata_r;
    logic [WORD_WIDTH-1:0] load_val_s;
    logic [WORD_WIDTH-1:0] merged_s;

    mem_lane_align #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_lane_align (
        .word        (mem_rdata),
        .lane        (lane_r),
        .size        (size_r),
        .is_unsigned (uns_r),
        .wdata       (wdata_r),
        .load_val    (load_val_s),
        .merged      (merged_s)
    );

    // Sub-word request attributes, needed again when the read data returns.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            size_r  <= 2'b00;
            uns_r   <= 1'b0;
            lane_r  <= 2'b00;
            wdata_r <= {WORD_WIDTH{1'b0}};
        end else if (accept_s) begin
            size_r  <= req_size;
            uns_r   <= req_unsigned;
            lane_r  <= req_addr[1:0];
            wdata_r <= req_wdata;
        end
    end

    assign unused_s = ^req_addr[WORD_WIDTH-1:MEM_AW+2];
`else
    assign unused_s = ^{req_unsigned, req_addr[WORD_WIDTH-1:MEM_AW+2]};
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; word stores skip the read, sub-word stores read first.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    if (bad_s) begin
                        state_next_s = ST_RESP;
                    end else if (req_we && (req_size == SIZE_W)) begin
                        state_next_s = ST_WR;
                    end else begin
                        state_next_s = ST_RD;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RD:   state_next_s = ST_CAP;
            ST_CAP: begin
                if (we_r) begin
                    state_next_s = ST_WR;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            ST_WR:   state_next_s = ST_RESP;
            ST_RESP: begin
                if (resp_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Moore output decode.
    always_comb begin
        req_ready  = (state_r == ST_IDLE);
        resp_valid = (state_r == ST_RESP);
        mem_read   = (state_r == ST_RD);
        mem_write  = (state_r == ST_WR);
    end

    // Request capture at acceptance and result capture in CAP; memory-side
    // address/data come from these registers so they stay stable per access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_r         <= 1'b0;
            word_idx_r   <= {MEM_AW{1'b0}};
            mem_wdata_r  <= {WORD_WIDTH{1'b0}};
            resp_rdata_r <= {WORD_WIDTH{1'b0}};
            resp_err_r   <= 1'b0;
        end else if (accept_s) begin
            we_r         <= req_we;
            word_idx_r   <= req_addr[MEM_AW+1:2];
            mem_wdata_r  <= req_we ? req_wdata : {WORD_WIDTH{1'b0}};
            resp_rdata_r <= {WORD_WIDTH{1'b0}};
            resp_err_r   <= bad_s;
        end else if (state_r == ST_CAP) begin
`ifdef MEM_ACCESS_SUBWORD_EN
            if (we_r) begin
                mem_wdata_r <= merged_s;
            end else begin
                resp_rdata_r <= load_val_s;
            end
`else
            resp_rdata_r <= mem_rdata;
`endif
        end
    end

    assign mem_addr   = {{(WORD_WIDTH-MEM_AW){1'b0}}, word_idx_r};
    assign mem_wdata  = mem_wdata_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Directed self-checking bench for mem_access_unit with a behavioural
// word-addressed memory (one-cycle registered read). Expectations for
// sub-word requests depend on MEM_ACCESS_SUBWORD_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    logic [31:0] mem [0:1023];
    logic        pre_en = 1'b0;
    logic [9:0]  pre_addr = 10'd0;
    logic [31:0] pre_data = 32'h0;

    int errors = 0;
    int checks = 0;
    int both_hi = 0;
    int lat, n_rd, n_wr;
    logic [31:0] wr_data, wr_addr, got_rdata;
    logic        got_err;

    always #5 clk = ~clk;

    mem_access_unit #(.WORD_WIDTH(32), .MEM_AW(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    // Data memory model: registered read, whole-word write, bench preload port.
    always @(posedge clk) begin
        if (mem_read) mem_rdata <= mem[mem_addr[9:0]];
        if (mem_write) mem[mem_addr[9:0]] <= mem_wdata;
        if (pre_en) mem[pre_addr] <= pre_data;
    end

    // Read and write strobes must never overlap.
    always @(negedge clk) begin
        if (mem_read && mem_write) both_hi++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    // Issue one request, count cycles until resp_valid (bounded), record strobes.
    task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic release_resp);
        @(negedge clk);
        req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; n_rd = 0; n_wr = 0; wr_data = 32'h0; wr_addr = 32'h0;
        do begin
            @(negedge clk);
            lat++;
            if (mem_read) n_rd++;
            if (mem_write) begin
                n_wr++; wr_data = mem_wdata; wr_addr = mem_addr;
            end
        end while (!resp_valid && lat < 12);
        got_rdata = resp_rdata;
        got_err   = resp_err;
        if (release_resp) finish_resp();
    endtask

    task automatic check_resp(input string tag, input int e_lat, input logic e_err,
                              input logic [31:0] e_rdata, input int e_rd, input int e_wr);
        check_eq({tag, ".lat"}, lat, e_lat);
        check_eq({tag, ".err"}, {31'd0, got_err}, {31'd0, e_err});
        check_eq({tag, ".rdata"}, got_rdata, e_rdata);
        check_eq({tag, ".nrd"}, n_rd, e_rd);
        check_eq({tag, ".nwr"}, n_wr, e_wr);
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = SIZE_W;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst.req_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("rst.resp_err", {31'd0, resp_err}, 32'd0);
        check_eq("rst.mem_read", {31'd0, mem_read}, 32'd0);
        check_eq("rst.mem_write", {31'd0, mem_write}, 32'd0);
        check_eq("rst.resp_rdata", resp_rdata, 32'h0);
        check_eq("rst.mem_addr", mem_addr, 32'h0);
        check_eq("rst.mem_wdata", mem_wdata, 32'h0);
        rst = 1'b1;

        // Word store then word load of the same address.
        run_req(1'b1, SIZE_W, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1);
        check_resp("wst", 2, 1'b0, 32'h0, 0, 1);
        check_eq("wst.addr", wr_addr, 32'd4);
        check_eq("wst.wdata", wr_data, 32'hDEADBEEF);
        check_eq("wst.mem", mem[4], 32'hDEADBEEF);
        @(negedge clk);
        check_eq("wst.ready_after", {31'd0, req_ready}, 32'd1);
        run_req(1'b0, SIZE_W, 1'b0, 32'h10, 32'h0, 1'b1);
        check_resp("wld", 3, 1'b0, 32'hDEADBEEF, 1, 0);

        // Sub-word loads from 0x80FF7F01.
        preload(10'd4, 32'h80FF7F01);
        run_req(1'b0, SIZE_B, 1'b0, 32'h12, 32'h0, 1'b1);
`ifdef MEM_ACCESS_SUBWORD_EN
        check_resp("lb12", 3, 1'b0, 32'hFFFFFFFF, 1, 0);
`else
        check_resp("lb12", 1, 1'b1, 32'h0, 0, 0);
`endif
        run_req(1'b0, SIZE_B, 1'b1, 32'h13, 32'h0, 1'b1);
`ifdef MEM_ACCESS_SUBWORD_EN
        check_resp("lbu13", 3, 1'b0, 32'h00000080, 1, 0);
`else
        check_resp("lbu13", 1, 1'b1, 32'h0, 0, 0);
`endif
        run_req(1'b0, SIZE_H, 1'b0, 32'h10, 32'h0, 1'b1);
`ifdef MEM_ACCESS_SUBWORD_EN
        check_resp("lh10", 3, 1'b0, 32'h00007F01, 1, 0);
`else
        check_resp("lh10", 1, 1'b1, 32'h0, 0, 0);
`endif
        run_req(1'b0, SIZE_H, 1'b0, 32'h12, 32'h0, 1'b1);
`ifdef MEM_ACCESS_SUBWORD_EN
        check_resp("lh12", 3, 1'b0, 32'hFFFF80FF, 1, 0);
`else
        check_resp("lh12", 1, 1'b1, 32'h0, 0, 0);
`endif

        // Stalled response: outputs hold, no new request accepted.
        run_req(1'b0, SIZE_W, 1'b0, 32'h10, 32'h0, 1'b0);
        check_resp("stall", 3, 1'b0, 32'h80FF7F01, 1, 0);
        req_we = 1'b0; req_size = SIZE_W; req_addr = 32'h20; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("stall.valid", {31'd0, resp_valid}, 32'd1);
            check_eq("stall.rdata", resp_rdata, 32'h80FF7F01);
            check_eq("stall.req_ready", {31'd0, req_ready}, 32'd0);
            check_eq("stall.mem_read", {31'd0, mem_read}, 32'd0);
        end
        req_valid = 1'b0;
        finish_resp();
        @(negedge clk);
        check_eq("stall.idle", {31'd0, req_ready}, 32'd1);

        // Byte and half stores via read-modify-write.
        preload(10'd4, 32'h11223344);
        run_req(1'b1, SIZE_B, 1'b0, 32'h11, 32'hFFFFFFAA, 1'b1);
`ifdef MEM_ACCESS_SUBWORD_EN
        check_resp("sb11", 4, 1'b0, 32'h0, 1, 1);
        check_eq("sb11.wdata", wr_data, 32'h1122AA44);
        check_eq("sb11.mem", mem[4], 32'h1122AA44);
`else
        check_resp("sb11", 1, 1'b1, 32'h0, 0, 0);
        check_eq("sb11.mem", mem[4], 32'h11223344);
`endif
        run_req(1'b1, SIZE_H, 1'b0, 32'h12, 32'h1234BEEF, 1'b1);
`ifdef MEM_ACCESS_SUBWORD_EN
        check_resp("sh12", 4, 1'b0, 32'h0, 1, 1);
        check_eq("sh12.mem", mem[4], 32'hBEEFAA44);
`else
        check_resp("sh12", 1, 1'b1, 32'h0, 0, 0);
        check_eq("sh12.mem", mem[4], 32'h11223344);
`endif

        // Error cases: misaligned word, misaligned half, reserved size.
        run_req(1'b0, SIZE_W, 1'b0, 32'h06, 32'h0, 1'b1);
        check_resp("wld06", 1, 1'b1, 32'h0, 0, 0);
        run_req(1'b1, SIZE_H, 1'b0, 32'h11, 32'h5555, 1'b1);
        check_resp("sh11", 1, 1'b1, 32'h0, 0, 0);
        run_req(1'b0, SIZE_RSV, 1'b0, 32'h10, 32'h0, 1'b1);
        check_resp("rsv", 1, 1'b1, 32'h0, 0, 0);

        // Reset just before the memory write of a store.
        preload(10'd4, 32'h11223344);
        @(negedge clk);
`ifdef MEM_ACCESS_SUBWORD_EN
        req_we = 1'b1; req_size = SIZE_B; req_addr = 32'h11; req_wdata = 32'hAA;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(negedge clk);
`else
        req_we = 1'b1; req_size = SIZE_W; req_addr = 32'h10; req_wdata = 32'h55667788;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
`endif
        rst = 1'b0;
        #1;
        check_eq("abort.req_ready", {31'd0, req_ready}, 32'd1);
        check_eq("abort.mem_write", {31'd0, mem_write}, 32'd0);
        check_eq("abort.mem_read", {31'd0, mem_read}, 32'd0);
        check_eq("abort.resp_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("abort.mem_addr", mem_addr, 32'h0);
        check_eq("abort.mem_wdata", mem_wdata, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check_eq("abort.mem", mem[4], 32'h11223344);
        run_req(1'b0, SIZE_W, 1'b0, 32'h10, 32'h0, 1'b1);
        check_resp("after_abort", 3, 1'b0, 32'h11223344, 1, 0);

        check_eq("strobe_overlap", both_hi, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
